byte_bank_arbiter: RTL and testbench
====================================

# byte_bank_arbiter

Shares a small bank of 8-bit registers between two requesters, A and B. Each cycle the block grants at most one access, read or write, to the single-ported bank. Arbitration is round-robin, and a requester can use a bounded lock to hold ownership for back-to-back accesses. The block sits between the byte-register datapath and two independent masters, and it is the only writer of the bank.

## Interface
Parameters:
- NREG, 4: number of 8-bit registers in the bank.
- AW, 2: address width; NREG = 2**AW.
- MAXHOLD, 4: maximum consecutive locked grants while the other side is waiting; range 1..15.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- NRST  in  1  synchronous, active-low reset, sampled on rising CLK.
- A_REQ  in  1  requester A wants an access; held until A_GNT.
- A_WE  in  1  1 = write, 0 = read; held with A_REQ.
- A_LOCK  in  1  A wants to keep ownership after this grant.
- A_ADDR  in  AW  register index.
- A_WDATA  in  8  write data.
- A_GNT  out  1  combinational; the access is performed at this rising edge.
- A_RDATA  out  8  registered read data.
- A_VALID  out  1  one-cycle pulse; A_RDATA is valid.
- B_REQ, B_WE, B_LOCK, B_ADDR, B_WDATA, B_GNT, B_RDATA, B_VALID: identical to the A ports, for requester B.

## Operation
- Internal state:
  - bank[0..NREG-1], 8 bits each.
  - PRI: side favoured on a tie; 0 = A, 1 = B.
  - OWN: NONE, A or B.
  - HCNT: 0..MAXHOLD, saturating.
- Grant decision (combinational, forced to no grant while NRST=0), evaluated in order:
  1. If OWN=X, X_REQ=1, and (the other side's REQ=0 or HCNT<MAXHOLD): grant X.
  2. Else if A_REQ=1 and B_REQ=1: grant the PRI side.
  3. Else grant the single requester, if any.
- At most one GNT is high in any cycle. A GNT never goes high without its REQ.
- On a grant to X, at the clock edge:
  - Write (X_WE=1): bank[X_ADDR] <= X_WDATA.
  - Read (X_WE=0): X_RDATA <= bank[X_ADDR], and X_VALID <= 1 for the next cycle.
  - PRI <= the other side.
  - If X_LOCK=1: OWN <= X, and HCNT <= (OWN was X ? min(HCNT+1, MAXHOLD) : 1).
  - If X_LOCK=0: OWN <= NONE and HCNT <= 0.
- Cycle with no grant: OWN <= NONE, HCNT <= 0, PRI unchanged.
- A forced release occurs when OWN=X holds HCNT=MAXHOLD and the other side is requesting. The other side is granted through rule 2, because PRI already points to it.
- A lock alone never blocks the other side indefinitely. If X drops REQ, ownership ends the same cycle.
- Both X_VALID outputs are 0 in any cycle not immediately following a read grant to that side. RDATA holds its last value otherwise.
- An address outside 0..NREG-1 cannot occur because NREG = 2**AW.

## Timing
- Reset (NRST=0 at an edge):
  - bank = all 0x00; PRI = A; OWN = NONE; HCNT = 0.
  - A_RDATA = B_RDATA = 0x00; A_VALID = B_VALID = 0.
  - A_GNT = B_GNT = 0 throughout reset.
- Reset in the middle of a lock or pending request:
  - No access is performed at that edge and the lock is cleared.
  - After release, arbitration restarts with A favoured.
- Grant latency:
  - 0 cycles when uncontended (GNT in the same cycle REQ rises).
  - Worst case for a waiting requester: MAXHOLD cycles.
- Read latency: 1 cycle. Data is on RDATA with VALID=1 in the cycle after GNT.
- Write then read of the same address:
  - The read is granted at the next edge and returns the new value.
  - A write and a read are never granted in the same cycle, so no bypass is needed.
- Throughput: one access per cycle, total across both sides.

## Test plan
- Reset, then uncontended traffic. A writes 0xA5 to addr 2 (A_GNT high the same cycle). A then reads addr 2 -> next cycle A_VALID=1, A_RDATA=0xA5. B reads addr 1 -> B_RDATA=0x00.
- Both sides hold unlocked write requests for 4 cycles -> grants alternate A, B, A, B (PRI starts at A). Exactly one GNT per cycle.
- A holds LOCK and REQ while B requests continuously, with MAXHOLD=4 -> A granted for 4 cycles, B on the 5th, then A and B alternate if A keeps locking.
- A locks with B idle for 10 cycles -> A granted in all 10 cycles. HCNT saturates at 4. B raises REQ at cycle 10 -> B granted at cycle 10.
- Assert NRST=0 during A's third locked cycle with B waiting. During reset both GNT=0, the bank is cleared and the locked access is not performed. After release with both requesting, A is granted first, and a read of any address returns 0x00.
- B writes 0x3C to addr 3, and A reads addr 3 in the next cycle -> A_RDATA=0x3C and B_VALID stays 0.

Source files
------------

// File: rtl/byte_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : byte_bank_arbiter
// Description : Round-robin arbiter with bounded lock sharing a single-ported
//               bank of 8-bit registers between requesters A and B.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_bank_arbiter #(
    parameter int NREG    = 4,
    parameter int AW      = 2,
    parameter int MAXHOLD = 4
) (
    input  logic          CLK,
    input  logic          NRST,
    input  logic          A_REQ,
    input  logic          A_WE,
    input  logic          A_LOCK,
    input  logic [AW-1:0] A_ADDR,
    input  logic [7:0]    A_WDATA,
    output logic          A_GNT,
    output logic [7:0]    A_RDATA,
    output logic          A_VALID,
    input  logic          B_REQ,
    input  logic          B_WE,
    input  logic          B_LOCK,
    input  logic [AW-1:0] B_ADDR,
    input  logic [7:0]    B_WDATA,
    output logic          B_GNT,
    output logic [7:0]    B_RDATA,
    output logic          B_VALID
);

    localparam logic [3:0] c_max_hold = 4'(MAXHOLD);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } own_t;

    logic [7:0]    r_bank [NREG];
    logic          r_pri;
    own_t          r_own;
    logic [3:0]    r_hcnt;
    logic [7:0]    r_a_rdata;
    logic [7:0]    r_b_rdata;
    logic          r_a_valid;
    logic          r_b_valid;

    logic          w_gnt_a;
    logic          w_gnt_b;
    logic          w_any;
    logic          w_we;
    logic          w_lock;
    logic [AW-1:0] w_addr;
    logic [7:0]    w_wdata;
    own_t          w_side;
    logic [3:0]    w_hcnt_next;

    // Owner keeps the bank unless the other side waits and the hold budget is spent.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (NRST) begin
            if (r_own == OWN_A && A_REQ && (!B_REQ || r_hcnt < c_max_hold)) begin
                w_gnt_a = 1'b1;
            end else if (r_own == OWN_B && B_REQ && (!A_REQ || r_hcnt < c_max_hold)) begin
                w_gnt_b = 1'b1;
            end else if (A_REQ && B_REQ) begin
                if (r_pri) begin
                    w_gnt_b = 1'b1;
                end else begin
                    w_gnt_a = 1'b1;
                end
            end else if (A_REQ) begin
                w_gnt_a = 1'b1;
            end else if (B_REQ) begin
                w_gnt_b = 1'b1;
            end
        end
    end

    always_comb begin
        w_any   = w_gnt_a | w_gnt_b;
        w_we    = w_gnt_b ? B_WE    : A_WE;
        w_lock  = w_gnt_b ? B_LOCK  : A_LOCK;
        w_addr  = w_gnt_b ? B_ADDR  : A_ADDR;
        w_wdata = w_gnt_b ? B_WDATA : A_WDATA;
        w_side  = w_gnt_b ? OWN_B   : OWN_A;
        if (r_own != w_side) begin
            w_hcnt_next = 4'd1;
        end else if (r_hcnt >= c_max_hold) begin
            w_hcnt_next = c_max_hold;
        end else begin
            w_hcnt_next = r_hcnt + 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            for (int i = 0; i < NREG; i++) begin
                r_bank[i] <= 8'h00;
            end
            r_pri     <= 1'b0;
            r_own     <= OWN_NONE;
            r_hcnt    <= 4'd0;
            r_a_rdata <= 8'h00;
            r_b_rdata <= 8'h00;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
        end else begin
            r_a_valid <= w_gnt_a & ~A_WE;
            r_b_valid <= w_gnt_b & ~B_WE;
            if (w_gnt_a && !A_WE) begin
                r_a_rdata <= r_bank[A_ADDR];
            end
            if (w_gnt_b && !B_WE) begin
                r_b_rdata <= r_bank[B_ADDR];
            end
            if (w_any) begin
                if (w_we) begin
                    r_bank[w_addr] <= w_wdata;
                end
                r_pri <= w_gnt_a;
                if (w_lock) begin
                    r_own  <= w_side;
                    r_hcnt <= w_hcnt_next;
                end else begin
                    r_own  <= OWN_NONE;
                    r_hcnt <= 4'd0;
                end
            end else begin
                r_own  <= OWN_NONE;
                r_hcnt <= 4'd0;
            end
        end
    end

    assign A_GNT   = w_gnt_a;
    assign B_GNT   = w_gnt_b;
    assign A_RDATA = r_a_rdata;
    assign B_RDATA = r_b_rdata;
    assign A_VALID = r_a_valid;
    assign B_VALID = r_b_valid;

endmodule
`default_nettype wire

// File: tb/tb_byte_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_bank_arbiter
// Description : Directed scoreboard bench for byte_bank_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_bank_arbiter;

    logic       CLK = 1'b0;
    logic       NRST;
    logic       A_REQ, A_WE, A_LOCK;
    logic [1:0] A_ADDR;
    logic [7:0] A_WDATA;
    logic       A_GNT, A_VALID;
    logic [7:0] A_RDATA;
    logic       B_REQ, B_WE, B_LOCK;
    logic [1:0] B_ADDR;
    logic [7:0] B_WDATA;
    logic       B_GNT, B_VALID;
    logic [7:0] B_RDATA;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] q_a [$];
    logic [7:0] q_b [$];
    logic [7:0] mdl [4];

    byte_bank_arbiter #(.NREG(4), .AW(2), .MAXHOLD(4)) dut (
        .CLK(CLK), .NRST(NRST),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_LOCK(A_LOCK), .A_ADDR(A_ADDR),
        .A_WDATA(A_WDATA), .A_GNT(A_GNT), .A_RDATA(A_RDATA), .A_VALID(A_VALID),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_LOCK(B_LOCK), .B_ADDR(B_ADDR),
        .B_WDATA(B_WDATA), .B_GNT(B_GNT), .B_RDATA(B_RDATA), .B_VALID(B_VALID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic drv_a(input logic req, input logic we, input logic lock,
                         input logic [1:0] addr, input logic [7:0] wdata);
        A_REQ = req; A_WE = we; A_LOCK = lock; A_ADDR = addr; A_WDATA = wdata;
    endtask

    task automatic drv_b(input logic req, input logic we, input logic lock,
                         input logic [1:0] addr, input logic [7:0] wdata);
        B_REQ = req; B_WE = we; B_LOCK = lock; B_ADDR = addr; B_WDATA = wdata;
    endtask

    // One clock: check grants before the edge, then read results after it.
    task automatic tick(input string tag, input logic ea, input logic eb);
        logic rd_a, rd_b;
        #1;
        chk({tag, ":A_GNT"}, {7'b0, A_GNT}, {7'b0, ea});
        chk({tag, ":B_GNT"}, {7'b0, B_GNT}, {7'b0, eb});
        rd_a = ea && !A_WE;
        rd_b = eb && !B_WE;
        if (rd_a) q_a.push_back(mdl[A_ADDR]);
        if (rd_b) q_b.push_back(mdl[B_ADDR]);
        if (!NRST) begin
            for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
        end else if (ea && A_WE) begin
            mdl[A_ADDR] = A_WDATA;
        end else if (eb && B_WE) begin
            mdl[B_ADDR] = B_WDATA;
        end
        @(posedge CLK);
        #1;
        chk({tag, ":A_VALID"}, {7'b0, A_VALID}, {7'b0, rd_a});
        chk({tag, ":B_VALID"}, {7'b0, B_VALID}, {7'b0, rd_b});
        if (rd_a) chk({tag, ":A_RDATA"}, A_RDATA, q_a.pop_front());
        if (rd_b) chk({tag, ":B_RDATA"}, B_RDATA, q_b.pop_front());
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
        NRST = 1'b0;
        drv_a(1'b1, 1'b1, 1'b0, 2'd0, 8'hFF);
        drv_b(1'b1, 1'b1, 1'b0, 2'd1, 8'hFF);
        tick("rst0", 1'b0, 1'b0);
        tick("rst1", 1'b0, 1'b0);
        NRST = 1'b1;
        drv_a(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        drv_b(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        chk("rst:A_RDATA", A_RDATA, 8'h00);
        chk("rst:B_RDATA", B_RDATA, 8'h00);

        // Uncontended traffic
        drv_a(1'b1, 1'b1, 1'b0, 2'd2, 8'hA5);
        tick("a_wr", 1'b1, 1'b0);
        drv_a(1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
        tick("a_rd", 1'b1, 1'b0);
        drv_a(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        drv_b(1'b1, 1'b0, 1'b0, 2'd1, 8'h00);
        tick("b_rd", 1'b0, 1'b1);

        // Contended unlocked writes alternate
        drv_a(1'b1, 1'b1, 1'b0, 2'd0, 8'h11);
        drv_b(1'b1, 1'b1, 1'b0, 2'd1, 8'h22);
        tick("rr0", 1'b1, 1'b0);
        tick("rr1", 1'b0, 1'b1);
        tick("rr2", 1'b1, 1'b0);
        tick("rr3", 1'b0, 1'b1);
        drv_a(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        drv_b(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        tick("idle0", 1'b0, 1'b0);

        // A locks against a continuously waiting B: forced release after MAXHOLD
        drv_a(1'b1, 1'b1, 1'b1, 2'd0, 8'h33);
        drv_b(1'b1, 1'b1, 1'b0, 2'd1, 8'h44);
        tick("lk1", 1'b1, 1'b0);
        tick("lk2", 1'b1, 1'b0);
        tick("lk3", 1'b1, 1'b0);
        tick("lk4", 1'b1, 1'b0);
        tick("lk5", 1'b0, 1'b1);
        tick("lk6", 1'b1, 1'b0);
        drv_a(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        drv_b(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        tick("idle1", 1'b0, 1'b0);

        // A locks with B idle, then B arrives after the hold count saturated
        drv_a(1'b1, 1'b0, 1'b1, 2'd1, 8'h00);
        for (int i = 0; i < 10; i++) tick($sformatf("solo%0d", i), 1'b1, 1'b0);
        drv_b(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        tick("b_late", 1'b0, 1'b1);
        drv_a(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        drv_b(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        tick("idle2", 1'b0, 1'b0);

        // Reset during A's third locked cycle with B waiting
        drv_a(1'b1, 1'b1, 1'b1, 2'd2, 8'h77);
        drv_b(1'b1, 1'b1, 1'b0, 2'd3, 8'h88);
        tick("mr1", 1'b1, 1'b0);
        tick("mr2", 1'b1, 1'b0);
        NRST = 1'b0;
        tick("mr3", 1'b0, 1'b0);
        tick("mr4", 1'b0, 1'b0);
        NRST = 1'b1;
        drv_a(1'b1, 1'b0, 1'b0, 2'd2, 8'h00);
        drv_b(1'b1, 1'b0, 1'b0, 2'd1, 8'h00);
        tick("post_a", 1'b1, 1'b0);
        drv_a(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        tick("post_b", 1'b0, 1'b1);

        // B write then A read of the same address
        drv_b(1'b1, 1'b1, 1'b0, 2'd3, 8'h3C);
        tick("b_wr3", 1'b0, 1'b1);
        drv_b(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        drv_a(1'b1, 1'b0, 1'b0, 2'd3, 8'h00);
        tick("a_rd3", 1'b1, 1'b0);
        drv_a(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
        tick("idle3", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
